// File: rtl/param_shift_ring_pkg.sv
// ----------------------------------------------------------------------------
// param_shift_ring_pkg
// Shared types and tables for the parameterised shift/rotate ring.
//   state_t    : burst FSM states (IDLE, SHIFT)
//   mode_t     : per-step operation applied to the register during a burst
//   SSEG_TABLE : active-low seven-segment codes {dp,g,f,e,d,c,b,a} for 0..F
// Related macro: SSEG_EN (enables the seven-segment output on the top level).
// ----------------------------------------------------------------------------
package param_shift_ring_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned SEG_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Encodings match the 3-bit mode input; 3'b111 behaves like HOLD.
    typedef enum logic [MODE_W-1:0] {
        SHL    = 3'b000,
        SHR    = 3'b001,
        ROL    = 3'b010,
        ROR    = 3'b011,
        JOHN_L = 3'b100,
        JOHN_R = 3'b101,
        HOLD   = 3'b110
    } mode_t;

    // Decimal point kept off (1) in every entry.
    localparam logic [SEG_W-1:0] SSEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage : param_shift_ring_pkg

// File: rtl/sseg_hex_decoder.sv
// ----------------------------------------------------------------------------
// sseg_hex_decoder
// Combinational hex digit to active-low seven-segment decoder.
//   hex : 4-bit value to display
//   seg : active-low segment code {dp,g,f,e,d,c,b,a}, dp always off
// Only instantiated by param_shift_ring when SSEG_EN is defined.
// ----------------------------------------------------------------------------
module sseg_hex_decoder
    import param_shift_ring_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg
);

    // Table lookup; all 16 entries populated so no default needed.
    always_comb begin
        seg = SSEG_TABLE[hex];
    end

endmodule : sseg_hex_decoder

// File: rtl/param_shift_ring.sv
// ----------------------------------------------------------------------------
// param_shift_ring
// Parallel-loadable shift register that executes multi-step bursts of a
// selected shift/rotate/Johnson operation, with a live population count.
//
// Parameters
//   WIDTH : register width (>= 2)
//   AMT_W : width of the burst length input
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low
//   en        : global enable; 0 freezes every register (done included)
//   load      : parallel load of data (wins over start, aborts a burst)
//   data      : parallel load value
//   serial_in : fill bit for SHL / SHR steps
//   mode      : burst operation, sampled when a burst starts
//   start     : burst request (ignored while busy)
//   amt       : number of steps in the burst (0 gives an immediate done)
//   Q         : register contents
//   ones      : population count of Q (combinational)
//   busy      : burst in progress (decoded from state)
//   done      : one-cycle pulse in the first IDLE cycle after a burst
//   seg_out   : active-low seven-segment code of ones[3:0] (SSEG_EN only)
// Macro: SSEG_EN adds seg_out and the seven-segment decoder.
// ----------------------------------------------------------------------------
module param_shift_ring
    import param_shift_ring_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(2 * WIDTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         load,
    input  logic [WIDTH-1:0]             data,
    input  logic                         serial_in,
    input  logic [MODE_W-1:0]            mode,
    input  logic                         start,
    input  logic [AMT_W-1:0]             amt,
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    output logic                         busy,
`ifdef SSEG_EN
    output logic                         done,
    output logic [SEG_W-1:0]             seg_out
`else
    output logic                         done
`endif
);

    localparam int unsigned OW = $clog2(WIDTH + 1);

    state_t           state;
    mode_t            mode_q;
    logic [AMT_W-1:0] cnt;

    // One burst step of the latched operation; unused encodings hold Q.
    function automatic logic [WIDTH-1:0] step_f(
        input logic [WIDTH-1:0] v,
        input mode_t            m,
        input logic             s
    );
        case (m)
            SHL:     step_f = {v[WIDTH-2:0], s};
            SHR:     step_f = {s, v[WIDTH-1:1]};
            ROL:     step_f = {v[WIDTH-2:0], v[WIDTH-1]};
            ROR:     step_f = {v[0], v[WIDTH-1:1]};
            JOHN_L:  step_f = {v[WIDTH-2:0], ~v[WIDTH-1]};
            JOHN_R:  step_f = {~v[0], v[WIDTH-1:1]};
            default: step_f = v;
        endcase
    endfunction

    // Burst FSM with register, counter and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q      <= '0;
            state  <= IDLE;
            mode_q <= SHL;
            cnt    <= '0;
            done   <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            if (load) begin
                // Load aborts any burst silently.
                Q     <= data;
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (amt == '0) begin
                                done <= 1'b1;
                            end else begin
                                mode_q <= mode_t'(mode);
                                cnt    <= amt;
                                state  <= SHIFT;
                            end
                        end
                    end
                    SHIFT: begin
                        Q   <= step_f(Q, mode_q, serial_in);
                        cnt <= cnt - AMT_W'(1);
                        // Last step: return to IDLE with done raised alongside.
                        if (cnt == AMT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    // Population count of Q, zero latency.
    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = ones + OW'(Q[i]);
        end
    end

`ifdef SSEG_EN
    // Zero-extend so narrow counts still feed a full nibble.
    logic [OW+3:0] ones_ext;
    logic [3:0]    ones_nib;

    always_comb begin
        ones_ext = {4'b0000, ones};
        ones_nib = ones_ext[3:0];
    end

    sseg_hex_decoder u_sseg (
        .hex (ones_nib),
        .seg (seg_out)
    );
`endif

endmodule : param_shift_ring

// File: tb/tb_param_shift_ring.sv
// ----------------------------------------------------------------------------
// tb_param_shift_ring
// Directed, table-driven bench for param_shift_ring (WIDTH=8) plus
// hand-written sequences for Johnson fills, enable gaps and async reset.
// ----------------------------------------------------------------------------
module tb_param_shift_ring;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] data;
    logic       serial_in;
    logic [2:0] mode;
    logic       start;
    logic [4:0] amt;
    logic [7:0] Q;
    logic [3:0] ones;
    logic       busy;
    logic       done;
`ifdef SSEG_EN
    logic [7:0] seg_out;
`endif

    int checks = 0;
    int errors = 0;

    param_shift_ring #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .data      (data),
        .serial_in (serial_in),
        .mode      (mode),
        .start     (start),
        .amt       (amt),
        .Q         (Q),
        .ones      (ones),
        .busy      (busy),
`ifdef SSEG_EN
        .done      (done),
        .seg_out   (seg_out)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       load;
        logic [7:0] data;
        logic       start;
        logic [2:0] mode;
        logic [4:0] amt;
        logic       sin;
        logic [7:0] q;
        logic [3:0] ones;
        logic       busy;
        logic       done;
    } vec_t;

    localparam int NV = 35;
    vec_t vt [NV];

    function automatic vec_t mk(input logic e, input logic l, input logic [7:0] d,
                                input logic s, input logic [2:0] m, input logic [4:0] a,
                                input logic si, input logic [7:0] q, input logic [3:0] o,
                                input logic b, input logic dn);
        vec_t v;
        v.en = e; v.load = l; v.data = d; v.start = s; v.mode = m; v.amt = a;
        v.sin = si; v.q = q; v.ones = o; v.busy = b; v.done = dn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        en = 1'b1; load = 1'b0; start = 1'b0; data = 8'h00;
        serial_in = 1'b0; mode = 3'b000; amt = 5'd0;
    endtask

`ifdef SSEG_EN
    function automatic logic [7:0] seg_ref(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0; 4'd1: return 8'hF9; 4'd2: return 8'hA4; 4'd3: return 8'hB0;
            4'd4: return 8'h99; 4'd5: return 8'h92; 4'd6: return 8'h82; 4'd7: return 8'hF8;
            4'd8: return 8'h80; default: return 8'h00;
        endcase
    endfunction
`endif

    int dn_cnt;
    int busy_cnt;

    initial begin
        // Stateful sequence: each row = inputs for one edge, then expected outputs.
        //           en load data  st mode  amt  sin  Q      ones busy done
        vt[0]  = mk(1, 1, 8'h07, 0, 3'd0, 5'd0, 0, 8'h07, 4'd3, 0, 0);
        vt[1]  = mk(1, 1, 8'h81, 0, 3'd0, 5'd0, 0, 8'h81, 4'd2, 0, 0);
        vt[2]  = mk(1, 0, 8'h00, 1, 3'd2, 5'd3, 0, 8'h81, 4'd2, 1, 0);
        vt[3]  = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h03, 4'd2, 1, 0);
        vt[4]  = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h06, 4'd2, 1, 0);
        vt[5]  = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h0C, 4'd2, 0, 1);
        vt[6]  = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h0C, 4'd2, 0, 0);
        vt[7]  = mk(1, 0, 8'h00, 1, 3'd0, 5'd2, 1, 8'h0C, 4'd2, 1, 0);
        vt[8]  = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 1, 8'h19, 4'd3, 1, 0);
        vt[9]  = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h32, 4'd3, 0, 1);
        vt[10] = mk(1, 0, 8'h00, 1, 3'd1, 5'd1, 1, 8'h32, 4'd3, 1, 0);
        vt[11] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 1, 8'h99, 4'd4, 0, 1);
        vt[12] = mk(1, 0, 8'h00, 1, 3'd5, 5'd2, 0, 8'h99, 4'd4, 1, 0);
        vt[13] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h4C, 4'd3, 1, 0);
        vt[14] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hA6, 4'd4, 0, 1);
        vt[15] = mk(1, 0, 8'h00, 1, 3'd6, 5'd2, 0, 8'hA6, 4'd4, 1, 0);
        vt[16] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hA6, 4'd4, 1, 0);
        vt[17] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hA6, 4'd4, 0, 1);
        vt[18] = mk(1, 0, 8'h00, 1, 3'd7, 5'd1, 0, 8'hA6, 4'd4, 1, 0);
        vt[19] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hA6, 4'd4, 0, 1);
        vt[20] = mk(1, 0, 8'h00, 1, 3'd2, 5'd0, 0, 8'hA6, 4'd4, 0, 1);
        vt[21] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hA6, 4'd4, 0, 0);
        vt[22] = mk(1, 0, 8'h00, 1, 3'd2, 5'd0, 0, 8'hA6, 4'd4, 0, 1);
        vt[23] = mk(1, 0, 8'h00, 1, 3'd2, 5'd1, 0, 8'hA6, 4'd4, 1, 0);
        vt[24] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h4D, 4'd4, 0, 1);
        vt[25] = mk(0, 0, 8'h00, 1, 3'd2, 5'd3, 0, 8'h4D, 4'd4, 0, 1);
        vt[26] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'h4D, 4'd4, 0, 0);
        vt[27] = mk(1, 0, 8'h00, 1, 3'd3, 5'd2, 0, 8'h4D, 4'd4, 1, 0);
        vt[28] = mk(1, 0, 8'h00, 1, 3'd2, 5'd7, 0, 8'hA6, 4'd4, 1, 0);
        vt[29] = mk(1, 0, 8'h00, 0, 3'd2, 5'd7, 0, 8'h53, 4'd4, 0, 1);
        vt[30] = mk(1, 0, 8'h00, 1, 3'd2, 5'd5, 0, 8'h53, 4'd4, 1, 0);
        vt[31] = mk(1, 1, 8'hA5, 1, 3'd2, 5'd5, 0, 8'hA5, 4'd4, 0, 0);
        vt[32] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hA5, 4'd4, 0, 0);
        vt[33] = mk(1, 1, 8'hFF, 1, 3'd2, 5'd3, 0, 8'hFF, 4'd8, 0, 0);
        vt[34] = mk(1, 0, 8'h00, 0, 3'd0, 5'd0, 0, 8'hFF, 4'd8, 0, 0);

        rst = 1'b0;
        idle_in();
        #3;
        check("reset_q", 32'(Q), 32'h00);
        check("reset_ones", 32'(ones), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            en = vt[i].en; load = vt[i].load; data = vt[i].data; start = vt[i].start;
            mode = vt[i].mode; amt = vt[i].amt; serial_in = vt[i].sin;
            tick();
            check($sformatf("row%0d_q", i), 32'(Q), 32'(vt[i].q));
            check($sformatf("row%0d_ones", i), 32'(ones), 32'(vt[i].ones));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            check($sformatf("row%0d_done", i), 32'(done), 32'(vt[i].done));
`ifdef SSEG_EN
            check($sformatf("row%0d_seg", i), 32'(seg_out), 32'(seg_ref(vt[i].ones)));
`endif
        end

        // Johnson-left fill from zero: 8 steps give all ones.
        idle_in(); load = 1'b1; data = 8'h00; tick();
        idle_in(); start = 1'b1; mode = 3'd4; amt = 5'd8; tick();
        idle_in();
        for (int i = 0; i < 8; i++) tick();
        check("john8_q", 32'(Q), 32'hFF);
        check("john8_ones", 32'(ones), 32'h8);
        check("john8_done", 32'(done), 32'h1);

        // Full Johnson cycle of 16 returns to zero with a single done.
        idle_in(); load = 1'b1; data = 8'h00; tick();
        idle_in(); start = 1'b1; mode = 3'd4; amt = 5'd16; tick();
        idle_in();
        dn_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dn_cnt++;
        end
        check("john16_q", 32'(Q), 32'h00);
        check("john16_done_count", 32'(dn_cnt), 32'd1);

        // ROR burst with a two-cycle enable gap after the first step.
        idle_in(); load = 1'b1; data = 8'h81; tick();
        busy_cnt = 0;
        idle_in(); start = 1'b1; mode = 3'd3; amt = 5'd4; tick();
        if (busy) busy_cnt++;
        idle_in(); tick();
        if (busy) busy_cnt++;
        check("ror_step1_q", 32'(Q), 32'hC0);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (busy) busy_cnt++;
            check($sformatf("ror_gap%0d_q", i), 32'(Q), 32'hC0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("ror_final_q", 32'(Q), 32'h18);
        check("ror_done", 32'(done), 32'h1);
        check("ror_busy_cycles", 32'(busy_cnt), 32'd6);

        // Asynchronous reset during a ROL burst at step 2.
        idle_in(); load = 1'b1; data = 8'h81; tick();
        idle_in(); start = 1'b1; mode = 3'd2; amt = 5'd5; tick();
        idle_in(); tick(); tick();
        check("rol_step2_q", 32'(Q), 32'h06);
        #2 rst = 1'b0;
        #1;
        check("arst_q", 32'(Q), 32'h00);
        check("arst_ones", 32'(ones), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_q", 32'(Q), 32'h00);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_done", 32'(done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_param_shift_ring

// File: doc/param_shift_ring.md
PARAM_SHIFT_RING -- requirements
Module: param_shift_ring

Interface
REQ-001 Parameter WIDTH, default 8, register width (>=2).
REQ-002 Parameter AMT_W, default $clog2(2*WIDTH)+1, width of burst-length input.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 en  input  1  global enable; 0 freezes all state except reset.
REQ-006 load  input  1  parallel-load request.
REQ-007 data  input  WIDTH  parallel-load value.
REQ-008 serial_in  input  1  fill bit for SHL/SHR modes.
REQ-009 mode  input  3  burst operation, sampled at start.
REQ-010 start  input  1  burst request.
REQ-011 amt  input  AMT_W  number of steps in burst.
REQ-012 Q  output  WIDTH  register contents.
REQ-013 ones  output  $clog2(WIDTH+1)  population count of Q.
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle pulse on burst completion.
REQ-016 seg_out  output  8  active-low seven-segment code {dp,g..a} of ones[3:0]; present only with SSEG_EN.

Function
REQ-017 Registered state: Q, FSM state {IDLE, SHIFT}, latched mode, step counter, done.
REQ-018 All updates occur on rising clk only when en=1; en=0 holds every register, done included.
REQ-019 load=1 (en=1) in any state: Q<=data next edge, state<=IDLE, busy=0, no done; load beats start.
REQ-020 IDLE, start=1, load=0, amt!=0: latch mode and amt, state<=SHIFT; first step on the following enabled edge.
REQ-021 IDLE, start=1, load=0, amt=0: no state change, Q unchanged, done=1 for exactly the next cycle.
REQ-022 SHIFT: each enabled edge applies one step to Q and decrements counter; after exactly amt steps state<=IDLE.
REQ-023 done=1 for one cycle coincident with the first IDLE cycle after the last step; done=0 otherwise.
REQ-024 busy = (state==SHIFT), combinational from state.
REQ-025 start while busy=1 is ignored; start in the cycle done=1 is accepted.
REQ-026 Step per mode: 000 SHL {Q[W-2:0],serial_in}; 001 SHR {serial_in,Q[W-1:1]}; 010 ROL; 011 ROR; 100 Johnson-left {Q[W-2:0],~Q[W-1]}; 101 Johnson-right {~Q[0],Q[W-1:1]}; 110/111 hold (step counted, Q unchanged).
REQ-027 mode/amt changes during SHIFT have no effect.
REQ-028 ones = popcount(Q), combinational, zero latency; exact for Q all-ones.

Reset
REQ-029 rst=0 asynchronously forces Q=0, ones=0, busy=0, done=0, state IDLE, counter 0, including mid-burst.
REQ-030 First enabled edge after rst release behaves as IDLE; no burst resumes.

Configuration
REQ-031 Macro SSEG_EN defined: seg_out present, hex code of ones[3:0] (0=0xC0, 3=0xB0, 8=0x80), dp=1, combinational from ones.
REQ-032 SSEG_EN undefined: seg_out port and decoder absent; all other behaviour identical.

Structure
REQ-033 Package param_shift_ring_pkg holds mode enum (SHL,SHR,ROL,ROR,JOHN_L,JOHN_R,HOLD) and the 16-entry seven-segment table.
REQ-034 Sub-module sseg_hex_decoder (4-bit in, 8-bit active-low out), instantiated only under SSEG_EN.

Verification (WIDTH=8)
REQ-035 rst=0 during ROL burst at step 2 -> Q=0x00, busy=0, done=0 immediately, before next edge.
REQ-036 en=1, load=1, data=0x07 -> Q=0x07, ones=3, seg_out=0xB0 (SSEG_EN) after one edge.
REQ-037 Q=0x81, start, mode=ROL, amt=3 -> Q 0x03,0x06,0x0C on successive edges; busy high 3 cycles; done pulse once.
REQ-038 Q=0x00, mode=JOHN_L, amt=8 -> Q=0xFF, ones=8; repeat amt=16 from 0x00 -> Q=0x00, done once.
REQ-039 Q=0x81 ROR amt=4, en=0 for 2 cycles after step 1 -> Q holds 0xC0, total busy 6 cycles, final Q=0x18.
REQ-040 load=1, data=0xA5 during SHIFT -> Q=0xA5, busy=0, no done; separately amt=0 start -> done one cycle, busy never 1.
